// File: rtl/regfile_write_queue_if.sv
// ---------------------------------------------------------------------------
// regfile_write_queue_if
//
// Bundles every non-clock, non-reset signal of the register-file write queue.
// The slave modport is the queue itself and the master modport is its
// environment: the producers, the decode stage and the register file.
//
// Signals:
//   flush                 discard all queued writes that have not issued yet
//   alu_valid/ready/addr/data   ALU writeback handshake
//   mem_valid/ready/addr/data   memory-load writeback handshake
//   we3/wa3/wd3           registered register-file write port
//   ra1/ra2               decode read addresses
//   byp1_hit/byp1_data    youngest pending value for ra1
//   byp2_hit/byp2_data    youngest pending value for ra2
//   pending               one bit per register with a write still in flight
//   count                 FIFO occupancy
//   stall_cnt             producer stall counter (only with RFWQ_STATS_EN)
// ---------------------------------------------------------------------------
interface regfile_write_queue_if #(
    parameter int WIDTH        = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int DEPTH        = 4
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic                       flush;
    logic                       alu_valid;
    logic                       alu_ready;
    logic [ADDRESSWIDTH-1:0]    alu_addr;
    logic [WIDTH-1:0]           alu_data;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [ADDRESSWIDTH-1:0]    mem_addr;
    logic [WIDTH-1:0]           mem_data;
    logic                       we3;
    logic [ADDRESSWIDTH-1:0]    wa3;
    logic [WIDTH-1:0]           wd3;
    logic [ADDRESSWIDTH-1:0]    ra1;
    logic [ADDRESSWIDTH-1:0]    ra2;
    logic                       byp1_hit;
    logic                       byp2_hit;
    logic [WIDTH-1:0]           byp1_data;
    logic [WIDTH-1:0]           byp2_data;
    logic [2**ADDRESSWIDTH-1:0] pending;
    logic [CNTW-1:0]            count;
`ifdef RFWQ_STATS_EN
    logic [15:0]                stall_cnt;
`endif

    // The write queue itself.
    modport slave (
`ifdef RFWQ_STATS_EN
        output stall_cnt,
`endif
        input  flush,
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  ra1, ra2,
        output alu_ready, mem_ready,
        output we3, wa3, wd3,
        output byp1_hit, byp2_hit, byp1_data, byp2_data,
        output pending, count
    );

    // Producers, decode stage and register file around the queue.
    modport master (
`ifdef RFWQ_STATS_EN
        input  stall_cnt,
`endif
        output flush,
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output ra1, ra2,
        input  alu_ready, mem_ready,
        input  we3, wa3, wd3,
        input  byp1_hit, byp2_hit, byp1_data, byp2_data,
        input  pending, count
    );
endinterface

// File: rtl/regfile_write_queue.sv
// ---------------------------------------------------------------------------
// regfile_write_queue
//
// Writer side of the register file. Writeback results from the ALU and the
// load unit are accepted through valid/ready handshakes (load has priority),
// buffered in a small FIFO and drained one write per cycle into a registered
// we3/wa3/wd3 port. Writes aimed at the PC alias register are accepted but
// dropped. For hazard handling the block reports which registers still have
// a write in flight and forwards the youngest in-flight value for both
// decode read addresses.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    regfile_write_queue_if.slave (handshakes, write port, bypass,
//          pending vector, occupancy)
//
// Build option:
//   RFWQ_STATS_EN  when defined, drives bus.stall_cnt: a saturating count of
//                  cycles in which a producer offered data that was refused.
// ---------------------------------------------------------------------------
module regfile_write_queue #(
    parameter int WIDTH        = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int DEPTH        = 4,
    parameter int PCADDR       = 7
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_write_queue_if.slave bus
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int NREG = 2 ** ADDRESSWIDTH;
    localparam logic [ADDRESSWIDTH-1:0] PC_A     = ADDRESSWIDTH'(PCADDR);
    localparam logic [CNTW-1:0]         FULL_CNT = CNTW'(DEPTH);

    logic [ADDRESSWIDTH-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0]        data_q [DEPTH];

    logic [PTRW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]         count_q, count_d;
    logic                    we3_q, we3_d;
    logic [ADDRESSWIDTH-1:0] wa3_q, wa3_d;
    logic [WIDTH-1:0]        wd3_q, wd3_d;

    logic                    full;
    logic                    empty;
    logic                    mem_fire;
    logic                    alu_fire;
    logic                    push_en;
    logic                    pop_en;
    logic [ADDRESSWIDTH-1:0] push_addr;
    logic [WIDTH-1:0]        push_data;

    logic [PTRW-1:0]         idx;
    logic                    hit1, hit2;
    logic [WIDTH-1:0]        val1, val2;
    logic [NREG-1:0]         pend;

    // Full is judged on the occupancy before this edge's pop, so a full
    // queue refuses everything even while it drains.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign bus.mem_ready = rst_n & ~full;
    assign bus.alu_ready = rst_n & ~full & ~bus.mem_valid;

    assign mem_fire  = bus.mem_valid & bus.mem_ready;
    assign alu_fire  = bus.alu_valid & bus.alu_ready;
    assign push_addr = mem_fire ? bus.mem_addr : bus.alu_addr;
    assign push_data = mem_fire ? bus.mem_data : bus.alu_data;

    // A PC-targeted beat completes its handshake but never enters the
    // queue; a flush drops whatever beat arrives alongside it.
    assign push_en = (mem_fire | alu_fire) & (push_addr != PC_A) & ~bus.flush;
    assign pop_en  = ~empty & ~bus.flush;

    // Pointer and occupancy update; flush restarts the ring from slot 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_d = count_q + 1'b1;
            else if (!push_en && pop_en) count_d = count_q - 1'b1;
        end
    end

    // The output register takes the head on a pop; otherwise the address
    // and data hold and only the enable drops.
    always_comb begin
        we3_d = pop_en;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (pop_en) begin
            wa3_d = addr_q[rd_ptr_q];
            wd3_d = data_q[rd_ptr_q];
        end
    end

    // Control state, cleared asynchronously so a reset drops we3 at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    // Entry storage needs no reset: the occupancy count decides which
    // slots are meaningful.
    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // Bypass and pending search. Candidates are visited oldest first (the
    // issuing write, then the FIFO from head to tail) so a later match
    // overwrites an earlier one and the youngest value wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        val1 = '0;
        val2 = '0;
        pend = '0;
        idx  = '0;
        if (we3_q) begin
            pend[wa3_q] = 1'b1;
            if (wa3_q == bus.ra1) begin
                hit1 = 1'b1;
                val1 = wd3_q;
            end
            if (wa3_q == bus.ra2) begin
                hit2 = 1'b1;
                val2 = wd3_q;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTRW'(i);
            if (CNTW'(i) < count_q) begin
                pend[addr_q[idx]] = 1'b1;
                if (addr_q[idx] == bus.ra1) begin
                    hit1 = 1'b1;
                    val1 = data_q[idx];
                end
                if (addr_q[idx] == bus.ra2) begin
                    hit2 = 1'b1;
                    val2 = data_q[idx];
                end
            end
        end
        pend[PC_A] = 1'b0;
        if (bus.ra1 == PC_A) hit1 = 1'b0;
        if (bus.ra2 == PC_A) hit2 = 1'b0;
    end

    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.count     = count_q;
    assign bus.pending   = pend;
    assign bus.byp1_hit  = hit1;
    assign bus.byp2_hit  = hit2;
    assign bus.byp1_data = val1;
    assign bus.byp2_data = val2;

`ifdef RFWQ_STATS_EN
    logic [15:0] stall_cnt_q;
    logic        stall;

    assign stall = (bus.alu_valid & ~bus.alu_ready) | (bus.mem_valid & ~bus.mem_ready);

    // Saturating count of refused offers; deliberately blind to flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
